// File: rtl/program_loader_if.sv
// Host/memory-side bundle of the program loader: start/length control,
// byte stream handshake, memory write port and load status.
interface program_loader_if #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 8
);
    logic                 Start;
    logic [AddrWidth:0]   Length;
    logic [7:0]           ByteData;
    logic                 ByteValid;
    logic                 ByteReady;
    logic [AddrWidth-1:0] MemAddr;
    logic [DataWidth-1:0] MemData;
    logic                 MemWr;
    logic                 Busy;
    logic                 Done;
    logic                 Error;
    logic                 CpuRun;

    modport master (
        output Start, Length, ByteData, ByteValid,
        input  ByteReady, MemAddr, MemData, MemWr, Busy, Done, Error, CpuRun
    );

    modport slave (
        input  Start, Length, ByteData, ByteValid,
        output ByteReady, MemAddr, MemData, MemWr, Busy, Done, Error, CpuRun
    );
endinterface

// File: rtl/program_loader.sv
// Fills program memory from a big-endian byte stream, one 16-bit word per two
// accepted bytes, and releases the CPU only after a complete, successful load.
module program_loader #(
    parameter int DataWidth     = 16,
    parameter int AddrWidth     = 8,
    parameter int TimeoutCycles = 1000
) (
    input logic              Clk,
    input logic              Reset,
    program_loader_if.slave  bus
);
    localparam int TmoWidth = $clog2(TimeoutCycles + 1);
    localparam logic [TmoWidth-1:0]  TmoLast = TmoWidth'(TimeoutCycles - 1);
    localparam logic [AddrWidth:0]   MaxLen  = {1'b1, {AddrWidth{1'b0}}};

    typedef enum logic [2:0] {
        S_Idle,
        S_HiByte,
        S_LoByte,
        S_Write,
        S_Done,
        S_Error
    } state_t;

    state_t               state, state_nxt;
    logic [AddrWidth:0]   len_q;
    logic [AddrWidth:0]   word_cnt;
    logic [AddrWidth:0]   word_nxt;
    logic [TmoWidth-1:0]  tmo_cnt;
    logic [AddrWidth-1:0] mem_addr;
    logic [DataWidth-1:0] mem_data;
    logic                 byte_ready;
    logic                 accept;
    logic                 mem_wr;
    logic                 busy;
    logic                 done;
    logic                 err;

    assign word_nxt = word_cnt + (AddrWidth+1)'(1);

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        accept     = 1'b0;
        mem_wr     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            S_Idle, S_Done, S_Error: begin
                done = (state == S_Done);
                err  = (state == S_Error);
                if (bus.Start) begin
                    if (bus.Length == '0)
                        state_nxt = S_Done;
                    else if (bus.Length > MaxLen)
                        state_nxt = S_Error;
                    else
                        state_nxt = S_HiByte;
                end
            end
            S_HiByte, S_LoByte: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                accept     = bus.ByteValid;
                if (accept)
                    state_nxt = (state == S_HiByte) ? S_LoByte : S_Write;
                else if (tmo_cnt == TmoLast)
                    state_nxt = S_Error;
            end
            S_Write: begin
                mem_wr    = 1'b1;
                busy      = 1'b1;
                state_nxt = (word_nxt == len_q) ? S_Done : S_HiByte;
            end
            default: state_nxt = S_Idle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_Idle;
            len_q    <= '0;
            word_cnt <= '0;
            tmo_cnt  <= '0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_Idle, S_Done, S_Error: begin
                    if (bus.Start) begin
                        len_q    <= bus.Length;
                        word_cnt <= '0;
                        tmo_cnt  <= '0;
                    end
                end
                S_HiByte: begin
                    if (accept) begin
                        mem_data[15:8] <= bus.ByteData;
                        tmo_cnt        <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TmoWidth'(1);
                    end
                end
                S_LoByte: begin
                    // Address is registered here so it is stable for the whole write cycle.
                    if (accept) begin
                        mem_data[7:0] <= bus.ByteData;
                        mem_addr      <= word_cnt[AddrWidth-1:0];
                        tmo_cnt       <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TmoWidth'(1);
                    end
                end
                S_Write: begin
                    word_cnt <= word_nxt;
                    tmo_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ByteReady = byte_ready;
    assign bus.MemWr     = mem_wr;
    assign bus.MemAddr   = mem_addr;
    assign bus.MemData   = mem_data;
    assign bus.Busy      = busy;
    assign bus.Done      = done;
    assign bus.Error     = err;
    assign bus.CpuRun    = done;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal loads, empty/oversize lengths,
// stalls, timeout abort, full-depth load and reset mid-load.
module tb_program_loader;
    localparam int DataWidth = 16;
    localparam int AddrWidth = 8;

    logic Clk;
    logic Reset;

    program_loader_if #(.DataWidth(DataWidth), .AddrWidth(AddrWidth)) bus ();

    program_loader #(
        .DataWidth    (DataWidth),
        .AddrWidth    (AddrWidth),
        .TimeoutCycles(8)
    ) u_dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [15:0] mem [0:255];

    always @(negedge Clk) begin
        if (bus.MemWr === 1'b1) begin
            mem[bus.MemAddr] = bus.MemData;
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_load(input logic [AddrWidth:0] len);
        bus.Start  = 1'b1;
        bus.Length = len;
        @(posedge Clk); #1;
        bus.Start  = 1'b0;
    endtask

    // Holds ByteValid high until the byte is accepted (ready seen before an edge).
    task automatic send_byte(input logic [7:0] b);
        logic r;
        bit   ok;
        ok            = 1'b0;
        bus.ByteData  = b;
        bus.ByteValid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge Clk);
            r = bus.ByteReady;
            @(posedge Clk); #1;
            if (r) ok = 1'b1;
        end
        if (!ok) check("byte_accept_timeout", 0, 1);
    endtask

    int base;

    initial begin
        Reset         = 1'b1;
        bus.Start     = 1'b0;
        bus.Length    = '0;
        bus.ByteData  = '0;
        bus.ByteValid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        @(negedge Clk);
        check("rst_busy",  bus.Busy,      0);
        check("rst_done",  bus.Done,      0);
        check("rst_error", bus.Error,     0);
        check("rst_cpu",   bus.CpuRun,    0);
        check("rst_ready", bus.ByteReady, 0);
        check("rst_memwr", bus.MemWr,     0);
        check("rst_addr",  bus.MemAddr,   0);
        check("rst_data",  bus.MemData,   0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // Two-word load with ByteValid held high
        base = wr_cnt;
        start_load(9'd2);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge Clk);
        check("t1_wr0",   bus.MemWr,   1);
        check("t1_addr0", bus.MemAddr, 0);
        check("t1_data0", bus.MemData, 16'h1234);
        send_byte(8'hAB);
        send_byte(8'hCD);
        bus.ByteValid = 1'b0;
        @(negedge Clk);
        check("t1_wr1",   bus.MemWr,   1);
        check("t1_addr1", bus.MemAddr, 1);
        check("t1_data1", bus.MemData, 16'hABCD);
        @(negedge Clk);
        check("t1_done",  bus.Done,    1);
        check("t1_cpu",   bus.CpuRun,  1);
        check("t1_busy",  bus.Busy,    0);
        check("t1_nowr",  bus.MemWr,   0);
        check("t1_count", wr_cnt - base, 2);
        check("t1_mem0",  mem[0],      16'h1234);

        // Empty load
        @(posedge Clk); #1;
        base = wr_cnt;
        start_load(9'd0);
        @(negedge Clk);
        @(negedge Clk);
        check("t2_done",  bus.Done,   1);
        check("t2_cpu",   bus.CpuRun, 1);
        check("t2_nowr",  wr_cnt - base, 0);

        // Single word with a 5-cycle gap between bytes
        @(posedge Clk); #1;
        base = wr_cnt;
        start_load(9'd1);
        send_byte(8'h5A);
        bus.ByteValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("t3_gap_ready", bus.ByteReady, 1);
        end
        @(posedge Clk); #1;
        send_byte(8'hC3);
        bus.ByteValid = 1'b0;
        @(negedge Clk);
        check("t3_wr",    bus.MemWr,   1);
        check("t3_addr",  bus.MemAddr, 0);
        check("t3_data",  bus.MemData, 16'h5AC3);
        @(negedge Clk);
        check("t3_done",  bus.Done,    1);
        check("t3_count", wr_cnt - base, 1);

        // Oversize length from the Done state
        @(posedge Clk); #1;
        start_load(9'd257);
        @(negedge Clk);
        check("t5_err",   bus.Error,  1);
        check("t5_done",  bus.Done,   0);
        check("t5_cpu",   bus.CpuRun, 0);

        // Full-depth load: 256 words, byte value = index[7:0]
        @(posedge Clk); #1;
        base = wr_cnt;
        start_load(9'd256);
        for (int i = 0; i < 512; i++) send_byte(8'(i));
        bus.ByteValid = 1'b0;
        @(negedge Clk);
        check("t5_lastwr",   bus.MemWr,   1);
        check("t5_lastaddr", bus.MemAddr, 8'hFF);
        check("t5_lastdata", bus.MemData, 16'hFEFF);
        @(negedge Clk);
        check("t5_done",  bus.Done,    1);
        check("t5_count", wr_cnt - base, 256);
        check("t5_mem00", mem[8'h00], 16'h0001);
        check("t5_mem10", mem[8'h10], 16'h2021);
        check("t5_mem80", mem[8'h80], 16'h0001);

        // Timeout after a lone high byte
        @(posedge Clk); #1;
        base = wr_cnt;
        start_load(9'd1);
        send_byte(8'h55);
        bus.ByteValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            check("t4_pre_err", bus.Error, 0);
        end
        @(negedge Clk);
        check("t4_err",   bus.Error,  1);
        check("t4_cpu",   bus.CpuRun, 0);
        check("t4_busy",  bus.Busy,   0);
        check("t4_nowr",  wr_cnt - base, 0);

        // Reset in the middle of a load, then restart
        @(posedge Clk); #1;
        start_load(9'd4);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        bus.ByteValid = 1'b0;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("t6_busy",  bus.Busy,      0);
        check("t6_done",  bus.Done,      0);
        check("t6_cpu",   bus.CpuRun,    0);
        check("t6_ready", bus.ByteReady, 0);
        @(posedge Clk); #1;
        start_load(9'd1);
        send_byte(8'h9A);
        send_byte(8'hBC);
        bus.ByteValid = 1'b0;
        @(negedge Clk);
        check("t6_wr",    bus.MemWr,   1);
        check("t6_addr",  bus.MemAddr, 0);
        check("t6_data",  bus.MemData, 16'h9ABC);
        @(negedge Clk);
        check("t6_done",  bus.Done,    1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
